// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's Memory stage and the data-memory responder.
// The core drives the request side and samples the response/stall side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rdata, resp_valid, err, stall
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rdata, resp_valid, err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with sized, sign/zero-extended access,
// a fixed number of wait states, and a combinational stall back to the pipeline.
module dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;

    logic        out_load_reg;
    logic [1:0]  out_size_reg;
    logic        out_uns_reg;
    logic [1:0]  out_lane_reg;
    logic        err_reg;

    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        misaligned;
    logic        enter_done;
    logic        access_fire;
    logic [3:0]  lane_mask;
    logic [3:0]  we_lane;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [31:0] rdata_next;
    logic [ADDR_BITS-1:0] word_idx;
    logic        unused_addr_bits;

    // In IDLE the access is decided from the live bus; afterwards only the captured copy counts.
    assign acc_we    = (state_reg == IDLE) ? bus.req_we       : we_reg;
    assign acc_size  = (state_reg == IDLE) ? bus.req_size     : size_reg;
    assign acc_uns   = (state_reg == IDLE) ? bus.req_unsigned : uns_reg;
    assign acc_addr  = (state_reg == IDLE) ? bus.req_addr     : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata    : wdata_reg;

    assign word_idx         = acc_addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^acc_addr[31:ADDR_BITS+2];

    always_comb begin
        misaligned = 1'b0;
        case (acc_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = acc_addr[0];
            2'b10:   misaligned = (acc_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned || (WAIT_CYCLES == 0)) begin
                        state_next = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A store that has not reached DONE when reset hits must never touch the RAM.
    assign access_fire = enter_done && !reset;

    always_comb begin
        lane_mask = 4'b0000;
        wr_word   = acc_wdata;
        case (acc_size)
            2'b00: begin
                lane_mask = 4'b0001 << acc_addr[1:0];
                wr_word   = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                wr_word   = acc_wdata;
            end
        endcase
    end

    assign we_lane = (access_fire && acc_we && !misaligned) ? lane_mask : 4'b0000;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (we_lane[gi]) begin
                    mem[word_idx] <= wr_word[gi*8 +: 8];
                end
                if (access_fire) begin
                    rd_reg <= mem[word_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            out_load_reg <= 1'b0;
            out_size_reg <= 2'b00;
            out_uns_reg  <= 1'b0;
            out_lane_reg <= 2'b00;
            err_reg      <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && bus.req_valid) begin
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
            end
            if (enter_done) begin
                out_load_reg <= !acc_we && !misaligned;
                out_size_reg <= acc_size;
                out_uns_reg  <= acc_uns;
                out_lane_reg <= acc_addr[1:0];
                err_reg      <= misaligned;
            end
        end
    end

    // Lane select and extension are applied to the registered RAM word, so rdata stays
    // a pure function of registers and holds until the next completed access.
    assign rd_shifted = rd_word >> {out_lane_reg, 3'b000};

    always_comb begin
        rdata_next = 32'd0;
        if (out_load_reg) begin
            case (out_size_reg)
                2'b00:   rdata_next = {{24{!out_uns_reg && rd_shifted[7]}}, rd_shifted[7:0]};
                2'b01:   rdata_next = {{16{!out_uns_reg && rd_shifted[15]}}, rd_shifted[15:0]};
                default: rdata_next = rd_word;
            endcase
        end
    end

    assign bus.rdata      = rdata_next;
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.err        = err_reg;
    assign bus.stall      = !reset && bus.req_valid && (state_reg != DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: one instance with two wait states,
// one with none, both checked against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int AB   = 10;
    localparam int MEMB = 4 << AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    dmem_responder_if bus_a();
    dmem_responder_if bus_b();

    dmem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    dmem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [7:0] mem_m [2][MEMB];
    int wcyc [2] = '{2, 0};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic set_bus(int d, logic v, logic we, logic [1:0] sz, logic un,
                           logic [31:0] a, logic [31:0] wd);
        if (d == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_size = sz;
            bus_a.req_unsigned = un; bus_a.req_addr = a; bus_a.req_wdata = wd;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_size = sz;
            bus_b.req_unsigned = un; bus_b.req_addr = a; bus_b.req_wdata = wd;
        end
    endtask

    function automatic logic get_stall(int d);
        return (d == 0) ? bus_a.stall : bus_b.stall;
    endfunction

    // Issue one request, update the reference memory, queue the expected response and
    // wait for the pipeline to be released. Optionally scramble addr/wdata in the first WAIT cycle.
    task automatic do_req(int d, logic we, logic [1:0] sz, logic un, logic [31:0] a,
                          logic [31:0] wd, bit chg = 1'b0,
                          logic [31:0] a2 = 32'd0, logic [31:0] wd2 = 32'd0);
        exp_t   e;
        int     n;
        int     nb;
        int     base;
        bit     mis;
        bit     released;
        longint v;
        nb   = 1 << sz;
        mis  = (sz == 2'b11) || ((int'(a[1:0]) % nb) != 0);
        base = int'(a % MEMB);
        e.err   = mis;
        e.rdata = 32'd0;
        e.lat   = mis ? 1 : wcyc[d] + 1;
        if (!mis) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mem_m[d][base + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (longint'(mem_m[d][base + i]) << (8 * i));
                if (!un && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
                e.rdata = v[31:0];
            end
        end
        e.cyc = cyc;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        $display("req dut%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 d, we, sz, un, a, wd, e.rdata, e.err);
        set_bus(d, 1'b1, we, sz, un, a, wd);
        n = 0;
        released = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_stall(d)) begin
                n++;
                if (chg && k == 1) set_bus(d, 1'b1, we, sz, un, a2, wd2);
            end else begin
                released = 1'b1;
                break;
            end
        end
        chk("stall_released", 32'(released), 32'd1);
        chk("stall_cycles", n, e.lat);
        @(posedge clk);
        #1;
        set_bus(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic mon(int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q_a.size() : q_b.size();
        if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", d);
            return;
        end
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        if (d == 0) begin
            chk("rdata_a", bus_a.rdata, e.rdata);
            chk("err_a", 32'(bus_a.err), 32'(e.err));
        end else begin
            chk("rdata_b", bus_b.rdata, e.rdata);
            chk("err_b", 32'(bus_b.err), 32'(e.err));
        end
        chk("latency", cyc - e.cyc, e.lat);
    endtask

    always @(negedge clk) if (bus_a.resp_valid === 1'b1) mon(0);
    always @(negedge clk) if (bus_b.resp_valid === 1'b1) mon(1);

    task automatic rand_op(int d);
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << 12);
        do_req(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_bus(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
        set_bus(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata_a", bus_a.rdata, 32'd0);
        chk("reset_resp_a", 32'(bus_a.resp_valid), 32'd0);
        chk("reset_err_a", 32'(bus_a.err), 32'd0);
        chk("reset_stall_a", 32'(bus_a.stall), 32'd0);
        chk("reset_rdata_b", bus_b.rdata, 32'd0);
        chk("reset_resp_b", 32'(bus_b.resp_valid), 32'd0);
        chk("reset_err_b", 32'(bus_b.err), 32'd0);
        chk("reset_stall_b", 32'(bus_b.stall), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        set_bus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        set_bus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;

        // Known contents for the random region on both instances.
        for (int i = 0; i < 16; i++) begin
            do_req(0, 1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom);
            do_req(1, 1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom);
        end

        do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0000);
        do_req(0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_0080);
        do_req(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'd0);
        do_req(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0);
        do_req(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h1234_5678);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        do_req(0, 1'b0, 2'b01, 1'b0, 32'h23, 32'd0);
        do_req(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'd0);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hCAFE_F00D);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0);

        do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0);
        set_bus(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1111_1111);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(negedge clk);
        chk("stall_in_reset", 32'(bus_a.stall), 32'd0);
        chk("resp_in_reset", 32'(bus_a.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        set_bus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_AAAA, 1'b1, 32'h44, 32'h1212_1212);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h44, 32'd0);

        for (int i = 0; i < 40; i++) rand_op(0);

        // Back-to-back store/load pairs with no idle gap on the zero-wait instance.
        for (int i = 0; i < 8; i++) begin
            a = 32'(4 * $urandom_range(0, 15));
            do_req(1, 1'b1, 2'b10, 1'b0, a, $urandom);
            do_req(1, 1'b0, 2'b10, 1'b0, a, 32'd0);
        end
        for (int i = 0; i < 30; i++) rand_op(1);

        repeat (5) @(posedge clk);
        chk("queue_a_drained", q_a.size(), 32'd0);
        chk("queue_b_drained", q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipelined core's Memory-stage load/store requests. It is the memory-side end of the core's ALUResultM / WriteDataM / ReadDataM interface.
- Holds a word-organised RAM and supports byte, half and word accesses with sign or zero extension.
- Inserts a parameterised number of wait states and back-pressures the pipeline through a stall output.
- Sits between the datapath M stage and the hazard unit; stall is ORed into StallF/StallD/StallE/StallM.

Parameters:
- ADDR_BITS, 10, word-address width; RAM depth is 2**ADDR_BITS 32-bit words.
- WAIT_CYCLES, 2, extra cycles per access beyond the minimum; range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  M-stage memory request present; held stable by the core while stall=1
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_unsigned  input  1  loads only: zero-extend (1) or sign-extend (0)
- req_addr  input  32  byte address (ALUResultM)
- req_wdata  input  32  store data, right-justified (WriteDataM)
- rdata  output  32  extended load data (ReadDataM); valid while resp_valid=1
- resp_valid  output  1  one-cycle pulse: access complete
- err  output  1  misaligned/reserved access flag, valid with resp_valid
- stall  output  1  combinational; 1 = hold pipeline

Behaviour:
- Reset values: state IDLE, counter 0, rdata 0, resp_valid 0, err 0.
- stall is forced to 0 while reset=1. RAM contents are not cleared by reset.
- Word index is req_addr[ADDR_BITS+1:2]. Address bits above that are ignored, so addresses alias and wrap modulo the RAM size.
- Misaligned conditions: half with addr[0]=1; word with addr[1:0]!=00; any req_size=11.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req_valid=1, capture we/size/unsigned/addr/wdata into internal registers.
  - If misaligned, go to DONE with err=1.
  - Else if WAIT_CYCLES=0, go to DONE.
  - Else go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - If cnt=0, go to DONE; else cnt decrements.
  - Input changes during WAIT are ignored; the captured values are used.
- Entry to DONE (aligned access only):
  - Store: writes the selected byte lanes. Byte writes lane addr[1:0] with wdata[7:0]. Half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. Word writes all lanes.
  - Load: rdata is registered, selected, and extended per size/unsigned.
  - Store: rdata=0.
  - Misaligned: no RAM write, rdata=0.
- DONE: resp_valid=1 for exactly one cycle, then unconditionally IDLE.
  - A new request presented in DONE is not accepted until the following IDLE cycle.
  - The core advances on the DONE cycle, so the next request arrives in IDLE.
- stall = req_valid AND (state != DONE).
  - A request sees stall high for WAIT_CYCLES+1 cycles.
  - rdata and resp_valid appear WAIT_CYCLES+1 cycles after acceptance.
- Reset asserted in WAIT or DONE:
  - Returns to IDLE next edge.
  - A pending store that has not reached DONE is dropped (no RAM write).
  - A store already written on DONE entry remains.
- req_valid=0 in IDLE: state holds, stall=0, outputs hold (resp_valid=0).

Test Plan:
- Word store then load, WAIT_CYCLES=2:
  - Store: addr 0x00000010, wdata 0xDEADBEEF, size 10 -> stall high 3 cycles, resp_valid pulse, err=0.
  - Load at the same address -> rdata 0xDEADBEEF after 3 stall cycles.
- Byte/half lanes and extension:
  - Store word 0x00000000 at 0x20, then byte 0x80 at 0x23.
  - Load byte signed at 0x23 -> 0xFFFFFF80. Load byte unsigned -> 0x00000080.
  - Load half signed at 0x22 -> 0xFFFF8000. Load word -> 0x80000000.
- Misaligned accesses:
  - Word store at 0x21 with 0x12345678 -> err=1, rdata=0, memory unchanged (word load at 0x20 returns 0x80000000).
  - Half load at 0x23 -> err=1. size=11 -> err=1.
- Wrap/alias, ADDR_BITS=10:
  - Store 0xCAFEF00D at 0x00001000 -> load at 0x00000000 returns 0xCAFEF00D.
- Reset mid-operation:
  - Word store 0x11111111 to 0x40 (prior contents 0x0), reset pulsed in WAIT cycle 1 -> no resp_valid, stall=0 during reset, load 0x40 returns 0x00000000.
  - Input change during WAIT: addr changed to 0x44 mid-request -> write lands at the originally captured 0x40.
- WAIT_CYCLES=0, back-to-back requests:
  - stall high exactly 1 cycle per request.
  - resp_valid pulses every 2 cycles.
  - No request is lost or duplicated over 8 consecutive alternating store/load pairs.
